seq_pattern_gen: RTL

//  Serial pattern transmitter: loads a PAT_W-bit pattern and emits it MSB-first, one bit per clk,
//  a programmable number of times with optional zero-gap bits between repetitions.

---
 rtl/seq_pattern_gen_pkg.sv | 15 +
 rtl/seq_pattern_gen_if.sv | 31 +++
 rtl/seq_pattern_gen_piso_shreg.sv | 36 +++
 rtl/seq_pattern_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
package seq_gen_pkg;

  // Controller states; encodings are fixed so waveforms read the same across tools.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Pattern recognised by the downstream "1010" detector; handy default for benches.
  localparam logic [3:0] DEF_PAT = 4'b1010;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Handshake, configuration and serial output bundle of the pattern generator.
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic [GAP_W-1:0] gap_in;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pat_cnt;

  // Controlling logic side.
  modport master (
    output start, abort, pat_in, rep_in, gap_in,
    input  x_out, x_valid, busy, done, pat_cnt
  );

  // Generator side.
  modport slave (
    input  start, abort, pat_in, rep_in, gap_in,
    output x_out, x_valid, busy, done, pat_cnt
  );

endinterface

// File: rtl/seq_pattern_gen_piso_shreg.sv
// Parallel-in serial-out shift register: parallel load, shift left, MSB out.
module piso_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PAT_W-1:0] load_data,
  input  logic             shift_en,
  output logic             msb
);

  logic [PAT_W-1:0] data_q, data_d;

  // Load has priority over shift; zeros enter at the LSB.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[PAT_W-2:0], 1'b0};
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: repeats a captured pattern MSB-first with optional zero gaps.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_left_q, rep_left_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Shift register holds the bits of the current repetition still to be presented;
  // the bit on x_out has already left it, so its MSB is always the next bit.
  logic             start_rep;
  logic [PAT_W-1:0] load_src;
  logic             sh_load;
  logic             sh_shift;
  logic             sh_msb;

  piso_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data ({load_src[PAT_W-2:0], 1'b0}),
    .shift_en  (sh_shift),
    .msb       (sh_msb)
  );

  // Next-state, counters and registered outputs; outputs default to the idle line.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_left_d = rep_left_q;
    gap_len_d  = gap_len_q;
    gap_cnt_d  = gap_cnt_q;
    bit_idx_d  = bit_idx_q;
    pat_cnt_d  = pat_cnt_q;
    x_out_d    = 1'b0;
    x_valid_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    start_rep  = 1'b0;
    load_src   = pat_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start && !bus.abort) begin
          pat_d      = bus.pat_in;
          rep_left_d = bus.rep_in;
          gap_len_d  = bus.gap_in;
          pat_cnt_d  = '0;
          if (bus.rep_in == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            load_src  = bus.pat_in;
            start_rep = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bit_idx_q != '0) begin
          sh_shift  = 1'b1;
          x_out_d   = sh_msb;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end else begin
          // Last bit of this repetition is on the line now.
          pat_cnt_d  = pat_cnt_q + CNT_W'(1);
          rep_left_d = rep_left_q - CNT_W'(1);
          if (rep_left_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (gap_len_q != '0) begin
            state_d   = ST_GAP;
            busy_d    = 1'b1;
            gap_cnt_d = gap_len_q;
          end else begin
            start_rep = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          start_rep = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          busy_d    = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Begin a repetition: present its MSB next cycle and park the rest in the shifter.
    if (start_rep) begin
      state_d   = ST_SHIFT;
      sh_load   = 1'b1;
      x_out_d   = load_src[PAT_W-1];
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
      bit_idx_d = IDX_LAST;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      rep_left_q <= '0;
      gap_len_q  <= '0;
      gap_cnt_q  <= '0;
      bit_idx_q  <= '0;
      pat_cnt_q  <= '0;
      x_out_q    <= 1'b0;
      x_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      rep_left_q <= rep_left_d;
      gap_len_q  <= gap_len_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_idx_q  <= bit_idx_d;
      pat_cnt_q  <= pat_cnt_d;
      x_out_q    <= x_out_d;
      x_valid_q  <= x_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.x_out   = x_out_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pat_cnt = pat_cnt_q;

endmodule
